// File: rtl/mem_port_initiator.sv
// Single-outstanding load/store initiator for the shared word-wide memory port (byte/half/word lanes, load extension).
// Optional MEM_RD_BYTE_SWAP_EN: byte-reverse read data before lane selection for big-endian packed responders.
module mem_port_initiator #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wr_data,
    output logic [3:0]        o_mem_wr_en,
    output logic              o_mem_rd_en,
    input  logic [31:0]       i_mem_rd_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_WR = 3'd1,
        ISSUE_RD = 3'd2,
        CAPTURE  = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              accept;
    logic              misaligned;
    logic [3:0]        be_d, be_q;
    logic [31:0]       wdata_d, wr_data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [1:0]        lane_q, size_q;
    logic              unsigned_q;
    logic [31:0]       rd_word, rdata_d, rdata_q;
    logic              err_q;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    assign accept = i_req_valid && o_req_ready;

    // Request decode: byte enables, lane-replicated store data, alignment check
    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'b0000;
        wdata_d    = i_req_wdata;
        case (i_req_size)
            2'b00: begin
                be_d    = 4'b0001 << i_req_addr[1:0];
                wdata_d = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = i_req_addr[0];
                be_d       = i_req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{i_req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = |i_req_addr[1:0];
                be_d       = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned)    state_d = RESP;
                    else if (i_req_we) state_d = ISSUE_WR;
                    else               state_d = ISSUE_RD;
                end
            end
            ISSUE_WR: state_d = RESP;
            ISSUE_RD: state_d = CAPTURE;
            CAPTURE:  state_d = RESP;
            RESP:     if (i_rsp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state_q == IDLE) && !rst;
        o_rsp_valid = (state_q == RESP);
        o_mem_wr_en = (state_q == ISSUE_WR) ? be_q : 4'b0000;
        o_mem_rd_en = (state_q == ISSUE_RD);
    end

`ifdef MEM_RD_BYTE_SWAP_EN
    assign rd_word = {i_mem_rd_data[7:0], i_mem_rd_data[15:8],
                      i_mem_rd_data[23:16], i_mem_rd_data[31:24]};
`else
    assign rd_word = i_mem_rd_data;
`endif

    assign rd_byte = rd_word[{lane_q, 3'b000} +: 8];
    assign rd_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rdata_d = rd_word;
        case (size_q)
            2'b00:   rdata_d = {{24{~unsigned_q & rd_byte[7]}}, rd_byte};
            2'b01:   rdata_d = {{16{~unsigned_q & rd_half[15]}}, rd_half};
            default: rdata_d = rd_word;
        endcase
    end

    // Response data clears at accept so stores and errors report zero
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            be_q       <= 4'b0000;
            mem_addr_q <= '0;
            wr_data_q  <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else if (accept) begin
            lane_q     <= i_req_addr[1:0];
            size_q     <= i_req_size;
            unsigned_q <= i_req_unsigned;
            be_q       <= be_d;
            mem_addr_q <= {i_req_addr[ADDR_W-1:2], 2'b00};
            wr_data_q  <= wdata_d;
            rdata_q    <= 32'h0;
            err_q      <= misaligned;
        end else if (state_q == CAPTURE) begin
            rdata_q    <= rdata_d;
        end
    end

    assign o_mem_addr    = mem_addr_q;
    assign o_mem_wr_data = wr_data_q;
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_err     = err_q;

endmodule

// File: tb/tb_mem_port_initiator.sv
// Bench for mem_port_initiator: table of requests with scoreboarded responses, plus hand-written
// reset, back-pressure, mid-transaction reset and throughput sequences.
module tb_mem_port_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wr_data;
    logic [3:0]  o_mem_wr_en;
    logic        o_mem_rd_en;
    logic [31:0] i_mem_rd_data;

    always #5 clk = ~clk;

    mem_port_initiator #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_addr     (i_req_addr),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wr_data  (o_mem_wr_data),
        .o_mem_wr_en    (o_mem_wr_en),
        .o_mem_rd_en    (o_mem_rd_en),
        .i_mem_rd_data  (i_mem_rd_data)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_maddr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    localparam int NVEC = 15;
    vec_t        vecs [NVEC];
    rsp_t        sb_q [$];
    rsp_t        cur_exp;
    logic [31:0] cur_mem = 32'h0;
    logic        mem_raw = 1'b0;
    int          checks  = 0;
    int          passed  = 0;
    int          cyc     = 0;

    // Memory model presents logical word (lane i = byte addr+i) in the responder's packing
    function automatic logic [31:0] mem_img(input logic [31:0] w);
`ifdef MEM_RD_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        i_mem_rd_data <= o_mem_rd_en ? (mem_raw ? cur_mem : mem_img(cur_mem)) : 32'h5A5A5A5A;

    always @(negedge clk)
        if (!rst && i_req_valid && o_req_ready) sb_q.push_back(cur_exp);

    always @(negedge clk) begin
        rsp_t e;
        if (!rst && o_rsp_valid && i_rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected: response 0x%08h with no request pending", o_rsp_rdata);
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata", o_rsp_rdata, e.rdata);
                check("rsp_err", 32'(o_rsp_err), 32'(e.err));
            end
        end
    end

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata);
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_wdata    = wdata;
        i_req_valid    = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!o_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_req_ready) begin
            checks++;
            $display("FAIL %s_ready_timeout: o_req_ready stayed 0, expected 1", tag);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat = -1;
        int wr_cnt = 0;
        int rd_cnt = 0;
        @(posedge clk); #1;
        wait_ready(tag);
        cur_mem = v.mem;
        cur_exp = '{v.exp_rdata, v.exp_err};
        drive_req(v.we, v.addr, v.size, v.uns, v.wdata);
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_mem_wr_en != 4'b0000) begin
                wr_cnt++;
                check({tag, "_wr_en"}, 32'(o_mem_wr_en), 32'(v.exp_be));
                check({tag, "_wr_data"}, o_mem_wr_data, v.exp_wdata);
                check({tag, "_wr_addr"}, o_mem_addr, v.exp_maddr);
            end
            if (o_mem_rd_en) begin
                rd_cnt++;
                check({tag, "_rd_addr"}, o_mem_addr, v.exp_maddr);
            end
            if (o_rsp_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_wr_cycles"}, 32'(wr_cnt), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        check({tag, "_rd_cycles"}, 32'(rd_cnt), (!v.we && !v.exp_err) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic throughput(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] mem, input rsp_t exp, input int gap, input string tag);
        int first = -1;
        int second = -1;
        @(posedge clk); #1;
        wait_ready(tag);
        cur_mem = mem;
        cur_exp = exp;
        drive_req(we, addr, size, 1'b0, 32'h0BAD_F00D);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (o_req_ready && i_req_valid) begin
                if (first < 0) first = cyc;
                else begin
                    second = cyc;
                    break;
                end
            end
        end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        check({tag, "_gap"}, 32'(second - first), 32'(gap));
        wait_ready(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //          we    addr           sz     uns   wdata          mem            be       exp_wdata      maddr          rdata          err   lat
        vecs[0]  = '{1'b1, 32'h00000010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 4'b1111, 32'hDEADBEEF, 32'h00000010, 32'h00000000, 1'b0, 1};
        vecs[1]  = '{1'b0, 32'h00000013, 2'b00, 1'b0, 32'h00000000, 32'h80123456, 4'b0000, 32'h00000000, 32'h00000010, 32'hFFFFFF80, 1'b0, 2};
        vecs[2]  = '{1'b0, 32'h00000013, 2'b00, 1'b1, 32'h00000000, 32'h80123456, 4'b0000, 32'h00000000, 32'h00000010, 32'h00000080, 1'b0, 2};
        vecs[3]  = '{1'b1, 32'h00000022, 2'b01, 1'b0, 32'h00001234, 32'h00000000, 4'b1100, 32'h12341234, 32'h00000020, 32'h00000000, 1'b0, 1};
        vecs[4]  = '{1'b0, 32'h00000021, 2'b01, 1'b0, 32'h00000000, 32'hFFFFFFFF, 4'b0000, 32'h00000000, 32'h00000020, 32'h00000000, 1'b1, 0};
        vecs[5]  = '{1'b1, 32'h00000005, 2'b00, 1'b0, 32'h000000AB, 32'h00000000, 4'b0010, 32'hABABABAB, 32'h00000004, 32'h00000000, 1'b0, 1};
        vecs[6]  = '{1'b0, 32'h00000032, 2'b01, 1'b0, 32'h00000000, 32'h9ABC1234, 4'b0000, 32'h00000000, 32'h00000030, 32'hFFFF9ABC, 1'b0, 2};
        vecs[7]  = '{1'b0, 32'h00000030, 2'b01, 1'b1, 32'h00000000, 32'h9ABC8001, 4'b0000, 32'h00000000, 32'h00000030, 32'h00008001, 1'b0, 2};
        vecs[8]  = '{1'b0, 32'h00000040, 2'b10, 1'b0, 32'h00000000, 32'hCAFEF00D, 4'b0000, 32'h00000000, 32'h00000040, 32'hCAFEF00D, 1'b0, 2};
        vecs[9]  = '{1'b1, 32'h00000042, 2'b10, 1'b0, 32'h11111111, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000040, 32'h00000000, 1'b1, 0};
        vecs[10] = '{1'b0, 32'h00000000, 2'b11, 1'b0, 32'h00000000, 32'h12345678, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 0};
        vecs[11] = '{1'b0, 32'h00000008, 2'b00, 1'b0, 32'h00000000, 32'h1234567F, 4'b0000, 32'h00000000, 32'h00000008, 32'h0000007F, 1'b0, 2};
        vecs[12] = '{1'b1, 32'h00000000, 2'b01, 1'b0, 32'hFFFF5678, 32'h00000000, 4'b0011, 32'h56785678, 32'h00000000, 32'h00000000, 1'b0, 1};
        vecs[13] = '{1'b0, 32'h00000001, 2'b00, 1'b0, 32'h00000000, 32'h0000C300, 4'b0000, 32'h00000000, 32'h00000000, 32'hFFFFFFC3, 1'b0, 2};
        vecs[14] = '{1'b1, 32'hFFFFFFF7, 2'b00, 1'b0, 32'h0000005C, 32'h00000000, 4'b1000, 32'h5C5C5C5C, 32'hFFFFFFF4, 32'h00000000, 1'b0, 1};

        rst = 1'b1;
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        drive_req(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        i_req_valid = 1'b0;
        cur_exp = '{32'h0, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(o_req_ready), 32'd0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_wr_en", 32'(o_mem_wr_en), 32'd0);
        check("rst_rd_en", 32'(o_mem_rd_en), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_wr_data", o_mem_wr_data, 32'd0);
        check("rst_rdata", o_rsp_rdata, 32'd0);
        check("rst_err", 32'(o_rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(o_req_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Response back-pressure: load held in RESP for 5 cycles with a competing request
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
        cur_mem = 32'h80123456;
        cur_exp = '{32'hFFFFFF80, 1'b0};
        drive_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        begin
            int n = 0;
            while (!o_rsp_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk); #1;
        cur_exp = '{32'h0, 1'b1};
        drive_req(1'b1, 32'h50, 2'b10, 1'b0, 32'h77777777);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
            check("bp_rdata", o_rsp_rdata, 32'hFFFFFF80);
            check("bp_req_ready", 32'(o_req_ready), 32'd0);
            check("bp_strobes", {27'd0, o_mem_rd_en, o_mem_wr_en}, 32'd0);
        end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        cur_exp = '{32'hFFFFFF80, 1'b0};
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("bp_release_req_ready", 32'(o_req_ready), 32'd1);

        // Reset while the read strobe is up: response must be discarded
        @(posedge clk); #1;
        cur_mem = 32'hCAFEF00D;
        cur_exp = '{32'hCAFEF00D, 1'b0};
        drive_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        check("mid_rst_rd_en_before", 32'(o_mem_rd_en), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_rd_en", 32'(o_mem_rd_en), 32'd0);
        check("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("mid_rst_req_ready_in_rst", 32'(o_req_ready), 32'd0);
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("mid_rst_req_ready_after", 32'(o_req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", {30'd0, o_rsp_valid, o_mem_rd_en}, 32'd0);
        end

        throughput(1'b0, 32'h40, 2'b10, 32'hCAFEF00D, '{32'hCAFEF00D, 1'b0}, 4, "tp_load");
        throughput(1'b1, 32'h10, 2'b10, 32'h0, '{32'h0, 1'b0}, 3, "tp_store");
        throughput(1'b0, 32'h03, 2'b11, 32'h0, '{32'h0, 1'b1}, 2, "tp_err");

`ifdef MEM_RD_BYTE_SWAP_EN
        mem_raw = 1'b1;
        run_vec('{1'b0, 32'h60, 2'b10, 1'b0, 32'h0, 32'h11223344, 4'b0000, 32'h0, 32'h60, 32'h44332211, 1'b0, 2}, "swap");
        mem_raw = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
